mem_arbiter: RTL and testbench

Two-master arbiter sharing the single memory data port between instruction fetch (master 0) and `execute` (master 1). Uses the same valid/ready semantics on both sides: writes are `wr_valid`/`wr_ready`, reads are `rd_ready` as the request and `rd_valid` as the data return. Supports locked bursts so an 8-beat vector load or store is never interleaved. Grants are round-robin, with a burst cap to bound starvation.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for a single memory data port.
//   Master 0 (instruction fetch) and master 1 (execute) each present an
//   address, write data/width, a write request (wr_valid/wr_ready) and a
//   read request (rd_ready/rd_valid). The granted master is muxed
//   combinationally onto the memory port. i_mX_lock keeps the grant across
//   beats for bursts, bounded by MAX_BURST beats per grant.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_mX_addr/data/wr_valid/wr_width/rd_ready/lock   master X request side
//   o_mX_wr_ready/rd_valid/data     master X response side (data broadcast)
//   o_mem_addr/data/wr_valid/wr_width/rd_ready        memory request side
//   i_mem_wr_ready/data/rd_valid    memory response side
//   o_grant                         one-hot owner {m1, m0}; 00 = idle
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  input  logic                  i_m0_wr_valid,
  input  logic [2:0]            i_m0_wr_width,
  output logic                  o_m0_wr_ready,
  input  logic                  i_m0_rd_ready,
  output logic                  o_m0_rd_valid,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  input  logic                  i_m0_lock,
  input  logic [31:0]           i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  input  logic                  i_m1_wr_valid,
  input  logic [2:0]            i_m1_wr_width,
  output logic                  o_m1_wr_ready,
  input  logic                  i_m1_rd_ready,
  output logic                  o_m1_rd_valid,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  input  logic                  i_m1_lock,
  output logic [31:0]           o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_wr_valid,
  output logic [2:0]            o_mem_wr_width,
  input  logic                  i_mem_wr_ready,
  output logic                  o_mem_rd_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_rd_valid,
  output logic [1:0]            o_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [4:0] BURST_CAP = 5'(MAX_BURST);

  state_t                r_state;
  logic                  r_last;
  logic [3:0]            r_beats;

  logic                  req0;
  logic                  req1;
  logic                  cur_req;
  logic                  oth_req;
  logic                  cur_lock;
  logic                  beat;
  logic [4:0]            beats_inc;

  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wr_valid;
  logic [2:0]            mem_wr_width;
  logic                  mem_rd_ready;

  assign req0 = i_m0_wr_valid | i_m0_rd_ready;
  assign req1 = i_m1_wr_valid | i_m1_rd_ready;

  assign cur_req  = (r_state == GNT1) ? req1 : req0;
  assign oth_req  = (r_state == GNT1) ? req0 : req1;
  assign cur_lock = (r_state == GNT1) ? i_m1_lock : i_m0_lock;

  // Port mux; a simultaneous write and read forwards only the write.
  always_comb begin
    mem_addr     = '0;
    mem_data     = '0;
    mem_wr_valid = 1'b0;
    mem_wr_width = '0;
    mem_rd_ready = 1'b0;
    case (r_state)
      GNT0: begin
        mem_addr     = i_m0_addr;
        mem_data     = i_m0_data;
        mem_wr_valid = i_m0_wr_valid;
        mem_wr_width = i_m0_wr_width;
        mem_rd_ready = i_m0_rd_ready & ~i_m0_wr_valid;
      end
      GNT1: begin
        mem_addr     = i_m1_addr;
        mem_data     = i_m1_data;
        mem_wr_valid = i_m1_wr_valid;
        mem_wr_width = i_m1_wr_width;
        mem_rd_ready = i_m1_rd_ready & ~i_m1_wr_valid;
      end
      default: ;
    endcase
  end

  assign beat      = (mem_wr_valid & i_mem_wr_ready) | (mem_rd_ready & i_mem_rd_valid);
  assign beats_inc = {1'b0, r_beats} + 5'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_beats <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beats <= '0;
          // r_last names the previous owner, so a tie goes to the other one.
          if (req0 && (!req1 || r_last)) r_state <= GNT0;
          else if (req1)                 r_state <= GNT1;
        end
        GNT0, GNT1: begin
          if (beat) begin
            if (cur_lock && (beats_inc < BURST_CAP)) begin
              r_beats <= beats_inc[3:0];
            end else begin
              // Release and re-arbitrate on the same edge: the other master
              // wins if it is waiting, so the cap actually bounds starvation.
              r_beats <= '0;
              r_last  <= (r_state == GNT1);
              if (oth_req)       r_state <= (r_state == GNT1) ? GNT0 : GNT1;
              else if (!cur_req) r_state <= IDLE;
            end
          end else if (!cur_req) begin
            r_state <= IDLE;
            r_beats <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_beats <= '0;
        end
      endcase
    end
  end

  assign o_mem_addr     = mem_addr;
  assign o_mem_data     = mem_data;
  assign o_mem_wr_valid = mem_wr_valid;
  assign o_mem_wr_width = mem_wr_width;
  assign o_mem_rd_ready = mem_rd_ready;

  assign o_m0_wr_ready = i_mem_wr_ready & mem_wr_valid & (r_state == GNT0);
  assign o_m1_wr_ready = i_mem_wr_ready & mem_wr_valid & (r_state == GNT1);
  assign o_m0_rd_valid = i_mem_rd_valid & mem_rd_ready & (r_state == GNT0);
  assign o_m1_rd_valid = i_mem_rd_valid & mem_rd_ready & (r_state == GNT1);

  assign o_m0_data = i_mem_data;
  assign o_m1_data = i_mem_data;

  assign o_grant = {r_state == GNT1, r_state == GNT0};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// every cycle compared against a transaction-level model of ownership.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;

  logic [31:0]   m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic          m_wr    [2];
  logic [2:0]    m_width [2];
  logic          m_rd    [2];
  logic          m_lock  [2];

  logic          o_m0_wr_ready, o_m1_wr_ready;
  logic          o_m0_rd_valid, o_m1_rd_valid;
  logic [DW-1:0] o_m0_data, o_m1_data;
  logic [31:0]   o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_mem_wr_valid;
  logic [2:0]    o_mem_wr_width;
  logic          o_mem_rd_ready;
  logic [1:0]    o_grant;

  logic          mem_wr_ready;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: owner 0 = idle, 1 = master 0, 2 = master 1.
  int owner = 0;
  int last  = 1;
  int beats = 0;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_m0_addr     (m_addr[0]),
    .i_m0_data     (m_wdata[0]),
    .i_m0_wr_valid (m_wr[0]),
    .i_m0_wr_width (m_width[0]),
    .o_m0_wr_ready (o_m0_wr_ready),
    .i_m0_rd_ready (m_rd[0]),
    .o_m0_rd_valid (o_m0_rd_valid),
    .o_m0_data     (o_m0_data),
    .i_m0_lock     (m_lock[0]),
    .i_m1_addr     (m_addr[1]),
    .i_m1_data     (m_wdata[1]),
    .i_m1_wr_valid (m_wr[1]),
    .i_m1_wr_width (m_width[1]),
    .o_m1_wr_ready (o_m1_wr_ready),
    .i_m1_rd_ready (m_rd[1]),
    .o_m1_rd_valid (o_m1_rd_valid),
    .o_m1_data     (o_m1_data),
    .i_m1_lock     (m_lock[1]),
    .o_mem_addr    (o_mem_addr),
    .o_mem_data    (o_mem_data),
    .o_mem_wr_valid(o_mem_wr_valid),
    .o_mem_wr_width(o_mem_wr_width),
    .i_mem_wr_ready(mem_wr_ready),
    .o_mem_rd_ready(o_mem_rd_ready),
    .i_mem_data    (mem_rdata),
    .i_mem_rd_valid(mem_rd_valid),
    .o_grant       (o_grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      m_addr[k]  = '0;
      m_wdata[k] = '0;
      m_wr[k]    = 1'b0;
      m_width[k] = '0;
      m_rd[k]    = 1'b0;
      m_lock[k]  = 1'b0;
    end
    mem_wr_ready = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rdata    = '0;
  endtask

  // Expected port values follow directly from who owns the port.
  task automatic check_outputs();
    logic [1:0]    g;
    logic [31:0]   a;
    logic [DW-1:0] d;
    logic          wv, rr;
    logic [2:0]    w;
    logic          wrdy [2];
    logic          rval [2];
    int            k;
    g = 2'b00; a = '0; d = '0; wv = 1'b0; rr = 1'b0; w = '0;
    wrdy[0] = 1'b0; wrdy[1] = 1'b0; rval[0] = 1'b0; rval[1] = 1'b0;
    if (owner != 0) begin
      k  = owner - 1;
      g  = (k == 0) ? 2'b01 : 2'b10;
      a  = m_addr[k];
      d  = m_wdata[k];
      wv = m_wr[k];
      w  = m_width[k];
      rr = m_rd[k] && !m_wr[k];
      wrdy[k] = mem_wr_ready && m_wr[k];
      rval[k] = mem_rd_valid && rr;
    end
    check("grant",        o_grant,        g);
    check("mem_addr",     o_mem_addr,     a);
    check("mem_data",     o_mem_data,     d);
    check("mem_wr_valid", o_mem_wr_valid, wv);
    check("mem_wr_width", o_mem_wr_width, w);
    check("mem_rd_ready", o_mem_rd_ready, rr);
    check("m0_wr_ready",  o_m0_wr_ready,  wrdy[0]);
    check("m1_wr_ready",  o_m1_wr_ready,  wrdy[1]);
    check("m0_rd_valid",  o_m0_rd_valid,  rval[0]);
    check("m1_rd_valid",  o_m1_rd_valid,  rval[1]);
    check("m0_data",      o_m0_data,      mem_rdata);
    check("m1_data",      o_m1_data,      mem_rdata);
  endtask

  // Ownership rules applied to the inputs present at a rising edge.
  task automatic model_edge();
    bit req [2];
    bit beat;
    int k, o;
    req[0] = m_wr[0] || m_rd[0];
    req[1] = m_wr[1] || m_rd[1];
    if (!i_rst_n) begin
      owner = 0; last = 1; beats = 0;
      return;
    end
    if (owner == 0) begin
      beats = 0;
      if (req[0] && req[1]) owner = (last == 1) ? 1 : 2;
      else if (req[0])      owner = 1;
      else if (req[1])      owner = 2;
    end else begin
      k = owner - 1;
      o = 1 - k;
      beat = (m_wr[k] && mem_wr_ready) || (m_rd[k] && !m_wr[k] && mem_rd_valid);
      if (beat) begin
        beats++;
        if (!(m_lock[k] && beats < MB)) begin
          beats = 0;
          last  = k;
          if (req[o])       owner = o + 1;
          else if (!req[k]) owner = 0;
        end
      end else if (!req[k]) begin
        owner = 0;
        beats = 0;
      end
    end
  endtask

  task automatic settle();
    #2;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    clear_inputs();

    // Reset state
    #3;
    check("rst_grant",    o_grant,        2'b00);
    check("rst_wr_valid", o_mem_wr_valid, 1'b0);
    check("rst_rd_ready", o_mem_rd_ready, 1'b0);
    check("rst_addr",     o_mem_addr,     32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Single read from m1 with two memory wait cycles
    m_rd[1] = 1'b1; m_addr[1] = 32'h100;
    step();
    settle(); check("rd_grant", o_grant, 2'b10); tick();
    step();
    mem_rd_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    settle();
    check("rd_valid", o_m1_rd_valid, 1'b1);
    check("rd_data",  o_m1_data,     32'hDEADBEEF);
    tick();
    clear_inputs();
    step();
    step();

    // Tie: m0 first, then m1 with no idle gap, then next tie to m0
    m_wr[0] = 1'b1; m_addr[0] = 32'h10; m_wdata[0] = 32'hA0; m_width[0] = 3'd4;
    m_wr[1] = 1'b1; m_addr[1] = 32'h20; m_wdata[1] = 32'hB1; m_width[1] = 3'd2;
    mem_wr_ready = 1'b1;
    step();
    settle(); check("tie_first", o_grant, 2'b01); tick();
    m_wr[0] = 1'b0;
    settle(); check("tie_second", o_grant, 2'b10); tick();
    m_wr[1] = 1'b0;
    step();
    m_wr[0] = 1'b1; m_wr[1] = 1'b1;
    step();
    settle(); check("tie_again", o_grant, 2'b01); tick();
    clear_inputs();
    step();

    // Locked reads by m1 against continuous m0 writes (cap MB applies)
    m_rd[1] = 1'b1; m_lock[1] = 1'b1; mem_rd_valid = 1'b1;
    m_wr[0] = 1'b1; m_addr[0] = 32'h40; m_width[0] = 3'd1; mem_wr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      m_addr[1] = 32'h200 + 32'(4 * i);
      mem_rdata = 32'h1000 + 32'(i);
      step();
    end
    clear_inputs();
    step();

    // Write and read at once from m0: only the write is forwarded
    m_wr[0] = 1'b1; m_rd[0] = 1'b1; m_wdata[0] = 32'h55; m_width[0] = 3'd1;
    step();
    settle();
    check("wr_rd_wv",    o_mem_wr_valid, 1'b1);
    check("wr_rd_rr",    o_mem_rd_ready, 1'b0);
    check("wr_rd_width", o_mem_wr_width, 3'd1);
    tick();
    clear_inputs();
    step();

    // Async reset in the middle of a locked m1 burst
    m_wr[1] = 1'b1; m_lock[1] = 1'b1; m_width[1] = 3'd4; m_addr[1] = 32'h300;
    mem_wr_ready = 1'b1;
    step();
    step();
    step();
    settle();
    i_rst_n = 1'b0;
    #1;
    check("arst_grant",    o_grant,        2'b00);
    check("arst_wr_valid", o_mem_wr_valid, 1'b0);
    check("arst_addr",     o_mem_addr,     32'h0);
    check("arst_m1_wrdy",  o_m1_wr_ready,  1'b0);
    owner = 0; last = 1; beats = 0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    m_wr[0] = 1'b1;
    step();
    settle(); check("arst_tie", o_grant, 2'b01); tick();
    clear_inputs();
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        m_addr[k]  = $urandom;
        m_wdata[k] = $urandom;
        m_wr[k]    = ($urandom_range(0, 2) == 0);
        m_rd[k]    = ($urandom_range(0, 2) == 0);
        m_lock[k]  = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: m_width[k] = 3'd0;
          1: m_width[k] = 3'd1;
          2: m_width[k] = 3'd2;
          default: m_width[k] = 3'd4;
        endcase
      end
      mem_wr_ready = ($urandom_range(0, 4) < 3);
      mem_rd_valid = ($urandom_range(0, 4) < 3);
      mem_rdata    = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
